mem_wr_sched: RTL and testbench
===============================

# mem_wr_sched

Write-port scheduler that shares one simple dual-port memory write port among NCH requesters. Each requester owns a fixed circular region of the memory, and the block grants one write per clock in round-robin order. It generates the region-relative address, tracks each region's fill level from free-credit pulses returned by the consumer, and drives the memory's waddr/data/we from registers. It sits directly in front of the memory macro, in the write clock domain.

## Interface
- NCH, 4: number of requesters/regions; power of two, 2..8.
- RAM_WW, 18: memory write data width.
- RAM_WD, 10: memory write address width.
- CH_AW, 8: log2 region depth in words; NCH·2^CH_AW ≤ 2^RAM_WD.

- wclk_int  in  1  write clock; all logic on rising edge.
- rst_int  in  1  reset, asynchronous, active-low.
- req_valid  in  NCH  per-channel write request.
- req_data  in  NCH·RAM_WW  per-channel data; channel c occupies bits [c·RAM_WW +: RAM_WW].
- req_ready  out  NCH  one-hot grant (combinational); transfer occurs when valid&ready.
- ch_free  in  NCH  one-cycle pulse: consumer released one word of channel c.
- waddr  out  RAM_WD  registered memory write address.
- data  out  RAM_WW  registered memory write data.
- we  out  1  registered memory write enable.
- ch_full  out  NCH  registered; level == 2^CH_AW.
- ch_level  out  NCH·(CH_AW+1)  registered fill count per channel.
- ch_wptr  out  NCH·CH_AW  registered next write offset per channel, for the read side.
- err_underflow  out  1  sticky; set by ch_free on an empty channel.

## Operation
- Eligible(c) = req_valid[c] & ~ch_full[c].
- Round-robin arbitration:
  - Search eligible channels starting at last_grant+1, modulo NCH.
  - At most one req_ready bit is high per cycle, and only for an eligible channel.
  - last_grant updates only on a grant.
- On grant to c:
  - waddr <= (c << CH_AW) | ch_wptr[c], zero-extended to RAM_WD.
  - data <= req_data[c].
  - we <= 1.
  - ch_wptr[c] <= ch_wptr[c] + 1, wrapping mod 2^CH_AW.
- No grant: we <= 0; waddr and data hold their last values.
- Level update per channel c:
  - +1 on grant to c, −1 on ch_free[c].
  - Both in the same cycle: level unchanged.
- ch_free[c] with level 0 and no grant to c that cycle: level stays 0 and err_underflow <= 1.
- ch_full is recomputed from the next-state level, so it is valid the cycle after the write.
- A channel at full with a same-cycle ch_free is not eligible that cycle; it becomes eligible the next cycle.
- Reset values:
  - we = 0, waddr = 0, data = 0.
  - All levels 0, all wptrs 0, ch_full = 0, err_underflow = 0.
  - last_grant = NCH−1, so channel 0 has first priority.

## Timing
- req_ready is combinational from req_valid and registered state; there is no combinational path from req_data.
- Accepted word appears on waddr/data/we one wclk_int after the handshake cycle; the memory writes it at the following edge.
- Throughput: one write per cycle aggregate.
- Worst-case wait per channel is NCH−1 cycles when it is eligible.
- ch_free takes effect on level and ch_full at the next edge.
- Asynchronous reset mid-burst: we drops immediately and any in-flight write is lost. Requesters must reissue.

## Structure
- Package mem_wr_sched_pkg holds:
  - CH_W = $clog2(NCH).
  - REGION_WORDS = 2^CH_AW.
  - Function region_base(c).
  - Parameter legality check.
- Sub-module rr_arbiter (NCH-wide, inputs eligible and last_grant, outputs one-hot grant and encoded index); purely combinational.
- The top level holds the pointer, level and output registers.

## Test plan
- Single channel: reset, then ch2 streams 3 words D0..D2 back-to-back.
  - Expect we high for 3 cycles with waddr 0x200, 0x201, 0x202 (CH_AW=8).
  - Expect ch_level[2] = 3.
- Arbitration: all 4 channels valid continuously.
  - Expect grants in order 0,1,2,3,0,1…, one per cycle.
  - Expect waddr region bits [9:8] cycling 0..3.
- Full: ch1 writes 256 words with no ch_free.
  - Expect ch_full[1] = 1 and req_ready[1] = 0 thereafter while others are still granted.
  - A single ch_free[1] pulse gives exactly one more grant; wptr[1] wraps to 0.
- Simultaneous events: grant to ch0 together with ch_free[0] at level 5.
  - Expect level stays 5.
  - Then ch_free[3] at level 0: expect err_underflow = 1 and level stays 0.
- Reset mid-operation: assert rst_int during a 4-channel burst.
  - Expect we = 0 asynchronously and all levels/wptrs 0.
  - After release, the first grant goes to ch0.

Source files
------------

// File: rtl/mem_wr_sched_pkg.sv
// mem_wr_sched_pkg
//   Shared constants and helpers for the memory write-port scheduler.
//   Default geometry: 4 requesters, 18-bit words, 1024-word memory,
//   256-word circular region per requester.
package mem_wr_sched_pkg;

    localparam int NCH_DEFAULT    = 4;
    localparam int RAM_WW_DEFAULT = 18;
    localparam int RAM_WD_DEFAULT = 10;
    localparam int CH_AW_DEFAULT  = 8;

    // Channel index width and region depth for the default geometry.
    localparam int CH_W         = $clog2(NCH_DEFAULT);
    localparam int REGION_WORDS = 2 ** CH_AW_DEFAULT;

    // First memory word of channel c's region.
    function automatic int unsigned region_base(input int unsigned c,
                                                input int unsigned ch_aw);
        return c << ch_aw;
    endfunction

    // NCH is a power of two in 2..8 and all regions fit in the memory.
    function automatic bit params_legal(input int nch, input int ram_ww,
                                        input int ram_wd, input int ch_aw);
        return (nch >= 2) && (nch <= 8) && ((nch & (nch - 1)) == 0) &&
               (ram_ww > 0) && (ch_aw > 0) &&
               ((nch * (2 ** ch_aw)) <= (2 ** ram_wd));
    endfunction

endpackage

// File: rtl/mem_wr_sched_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. The search starts at the channel
//   after last_grant and wraps modulo NCH (NCH is a power of two, so the
//   wrap is the natural overflow of the index adder).
//   Ports:
//     eligible   in  NCH    channels that may be granted this cycle
//     last_grant in  IDX_W  most recently granted channel
//     grant      out NCH    one-hot grant, all zero when nothing eligible
//     grant_idx  out IDX_W  encoded index of the granted channel
module rr_arbiter #(
    parameter int NCH   = 4,
    parameter int IDX_W = $clog2(NCH)
) (
    input  logic [NCH-1:0]   eligible,
    input  logic [IDX_W-1:0] last_grant,
    output logic [NCH-1:0]   grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned; otherwise a latch would be inferred.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        // i == NCH wraps back to last_grant itself, searched last.
        for (int i = 1; i <= NCH; i++) begin
            cand = last_grant + IDX_W'(i);
            if (!found && eligible[cand]) begin
                found           = 1'b1;
                grant[cand]     = 1'b1;
                grant_idx       = cand;
            end
        end
    end

endmodule

// File: rtl/mem_wr_sched.sv
// mem_wr_sched
//   Shares one memory write port among NCH requesters, one write per
//   clock in round-robin order. Each requester owns a circular region of
//   2^CH_AW words starting at c << CH_AW. Fill levels rise on each write
//   and fall on consumer free pulses; a full channel is not granted.
//   Ports:
//     wclk_int, rst_int     clock, async active-low reset
//     req_valid/req_data    per-channel write requests (data packed by c)
//     req_ready             one-hot combinational grant
//     ch_free               per-channel one-word release pulse
//     waddr/data/we         registered memory write port
//     ch_full/ch_level      registered per-channel fill state
//     ch_wptr               registered next write offset per channel
//     err_underflow         sticky: free pulse seen on an empty channel
module mem_wr_sched
    import mem_wr_sched_pkg::*;
#(
    parameter int NCH    = NCH_DEFAULT,
    parameter int RAM_WW = RAM_WW_DEFAULT,
    parameter int RAM_WD = RAM_WD_DEFAULT,
    parameter int CH_AW  = CH_AW_DEFAULT
) (
    input  logic                       wclk_int,
    input  logic                       rst_int,
    input  logic [NCH-1:0]             req_valid,
    input  logic [NCH*RAM_WW-1:0]      req_data,
    output logic [NCH-1:0]             req_ready,
    input  logic [NCH-1:0]             ch_free,
    output logic [RAM_WD-1:0]          waddr,
    output logic [RAM_WW-1:0]          data,
    output logic                       we,
    output logic [NCH-1:0]             ch_full,
    output logic [NCH*(CH_AW+1)-1:0]   ch_level,
    output logic [NCH*CH_AW-1:0]       ch_wptr,
    output logic                       err_underflow
);

    localparam int              IDX_W      = $clog2(NCH);
    localparam logic [CH_AW:0]  FULL_LEVEL = (CH_AW+1)'(1) << CH_AW;

    if (!params_legal(NCH, RAM_WW, RAM_WD, CH_AW)) begin : g_bad_params
        $error("mem_wr_sched: illegal NCH/RAM_WW/RAM_WD/CH_AW combination");
    end

    logic [NCH-1:0][CH_AW:0]   level_q;
    logic [NCH-1:0][CH_AW:0]   level_next;
    logic [NCH-1:0][CH_AW-1:0] wptr_q;
    logic [IDX_W-1:0]          last_grant;
    logic [NCH-1:0]            eligible;
    logic [NCH-1:0]            grant;
    logic [IDX_W-1:0]          grant_idx;
    logic                      grant_any;
    logic                      underflow;

    // ch_full is registered, so a full channel with a same-cycle free pulse
    // stays ineligible until the following cycle.
    assign eligible  = req_valid & ~ch_full;
    assign grant_any = |grant;
    assign req_ready = grant;
    assign ch_level  = level_q;
    assign ch_wptr   = wptr_q;

    rr_arbiter #(
        .NCH   (NCH),
        .IDX_W (IDX_W)
    ) u_arb (
        .eligible   (eligible),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // Write and free in the same cycle cancel. A free on an empty channel
    // that is not also being written leaves the level at 0 and flags.
    always_comb begin
        level_next = level_q;
        underflow  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            case ({grant[c], ch_free[c]})
                2'b10: level_next[c] = level_q[c] + (CH_AW+1)'(1);
                2'b01: begin
                    if (level_q[c] == '0) underflow = 1'b1;
                    else level_next[c] = level_q[c] - (CH_AW+1)'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge wclk_int or negedge rst_int) begin
        if (!rst_int) begin
            // NOTE: the per-channel level/pointer arrays are a handful of
            // flops, not a RAM, so they are reset like any other register.
            we            <= 1'b0;
            waddr         <= '0;
            data          <= '0;
            level_q       <= '0;
            wptr_q        <= '0;
            ch_full       <= '0;
            err_underflow <= 1'b0;
            last_grant    <= IDX_W'(NCH - 1);
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            we <= grant_any;
            if (grant_any) begin
                waddr <= RAM_WD'(region_base(32'(grant_idx), CH_AW))
                       | RAM_WD'(wptr_q[grant_idx]);
                data  <= req_data[grant_idx*RAM_WW +: RAM_WW];
                wptr_q[grant_idx] <= wptr_q[grant_idx] + CH_AW'(1);
                last_grant        <= grant_idx;
            end
            level_q <= level_next;
            for (int c = 0; c < NCH; c++) begin
                ch_full[c] <= (level_next[c] == FULL_LEVEL);
            end
            if (underflow) err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_wr_sched.sv
// tb_mem_wr_sched
//   Self-checking bench for mem_wr_sched: directed vector table, hand
//   sequences for full/simultaneous/reset corners, and randomized traffic
//   compared against a behavioural model of regions and fill levels.
module tb_mem_wr_sched;

    localparam int NCH    = 4;
    localparam int RAM_WW = 18;
    localparam int RAM_WD = 10;
    localparam int CH_AW  = 8;
    localparam int DEPTH  = 2 ** CH_AW;
    localparam int LW     = CH_AW + 1;

    logic                     wclk_int;
    logic                     rst_int;
    logic [NCH-1:0]           req_valid;
    logic [NCH*RAM_WW-1:0]    req_data;
    logic [NCH-1:0]           req_ready;
    logic [NCH-1:0]           ch_free;
    logic [RAM_WD-1:0]        waddr;
    logic [RAM_WW-1:0]        data;
    logic                     we;
    logic [NCH-1:0]           ch_full;
    logic [NCH*LW-1:0]        ch_level;
    logic [NCH*CH_AW-1:0]     ch_wptr;
    logic                     err_underflow;

    mem_wr_sched #(
        .NCH    (NCH),
        .RAM_WW (RAM_WW),
        .RAM_WD (RAM_WD),
        .CH_AW  (CH_AW)
    ) dut (
        .wclk_int      (wclk_int),
        .rst_int       (rst_int),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .ch_free       (ch_free),
        .waddr         (waddr),
        .data          (data),
        .we            (we),
        .ch_full       (ch_full),
        .ch_level      (ch_level),
        .ch_wptr       (ch_wptr),
        .err_underflow (err_underflow)
    );

    initial begin
        wclk_int = 1'b0;
        forever #5 wclk_int = ~wclk_int;
    end

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain integers per region.
    int              m_lvl[NCH];
    int              m_wp[NCH];
    int              m_last;
    logic            m_we;
    int              m_waddr;
    logic [RAM_WW-1:0] m_data;
    logic            m_err;

    logic [NCH-1:0]  rdy_seen;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_lvl[c] = 0;
            m_wp[c]  = 0;
        end
        m_last  = NCH - 1;
        m_we    = 1'b0;
        m_waddr = 0;
        m_data  = '0;
        m_err   = 1'b0;
    endtask

    // Next channel after the last grant that wants to write and has room.
    function automatic int model_pick(input logic [NCH-1:0] v);
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (m_last + k) % NCH;
            if (v[c] && m_lvl[c] < DEPTH) return c;
        end
        return -1;
    endfunction

    task automatic check_state(input string tag);
        logic [NCH*LW-1:0]    e_lvl;
        logic [NCH*CH_AW-1:0] e_wp;
        logic [NCH-1:0]       e_full;
        for (int c = 0; c < NCH; c++) begin
            e_lvl[c*LW +: LW]       = LW'(m_lvl[c]);
            e_wp[c*CH_AW +: CH_AW]  = CH_AW'(m_wp[c]);
            e_full[c]               = (m_lvl[c] == DEPTH);
        end
        check({tag, ".we"},    64'(we),            64'(m_we));
        check({tag, ".waddr"}, 64'(waddr),         64'(m_waddr));
        check({tag, ".data"},  64'(data),          64'(m_data));
        check({tag, ".level"}, 64'(ch_level),      64'(e_lvl));
        check({tag, ".wptr"},  64'(ch_wptr),       64'(e_wp));
        check({tag, ".full"},  64'(ch_full),       64'(e_full));
        check({tag, ".err"},   64'(err_underflow), 64'(m_err));
    endtask

    // One clock: drive at negedge, check the grant, then check registers
    // just after the rising edge.
    task automatic cycle(input logic [NCH-1:0] v, input logic [NCH-1:0] f);
        logic [NCH*RAM_WW-1:0] d;
        logic [NCH-1:0]        e_rdy;
        int                    g;
        for (int c = 0; c < NCH; c++) d[c*RAM_WW +: RAM_WW] = RAM_WW'($urandom);
        @(negedge wclk_int);
        req_valid = v;
        ch_free   = f;
        req_data  = d;
        #1;
        g        = model_pick(v);
        e_rdy    = (g >= 0) ? (NCH'(1) << g) : '0;
        rdy_seen = req_ready;
        check("ready", 64'(req_ready), 64'(e_rdy));
        @(posedge wclk_int);
        if (g >= 0) begin
            m_we    = 1'b1;
            m_waddr = g * DEPTH + m_wp[g];
            m_data  = d[g*RAM_WW +: RAM_WW];
            m_wp[g] = (m_wp[g] + 1) % DEPTH;
            m_last  = g;
        end else begin
            m_we = 1'b0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (g == c && !f[c]) m_lvl[c]++;
            else if (g != c && f[c]) begin
                if (m_lvl[c] == 0) m_err = 1'b1;
                else m_lvl[c]--;
            end
        end
        #1;
        check_state("post");
    endtask

    task automatic do_reset();
        @(negedge wclk_int);
        rst_int   = 1'b0;
        req_valid = '0;
        ch_free   = '0;
        #1;
        model_reset();
        check_state("reset");
        repeat (2) @(negedge wclk_int);
        rst_int = 1'b1;
    endtask

    typedef struct {
        bit             rst_first;
        logic [NCH-1:0] v;
        logic [NCH-1:0] exp_ready;
        int             exp_waddr;
        int             exp_lvl2;   // -1: not checked
    } vec_t;

    vec_t tbl[9];

    initial begin
        rst_int   = 1'b1;
        req_valid = '0;
        ch_free   = '0;
        req_data  = '0;
        model_reset();

        // Single-channel stream on ch2, then 4-way round robin from reset.
        tbl[0] = '{1'b1, 4'b0100, 4'b0100, 'h200, -1};
        tbl[1] = '{1'b0, 4'b0100, 4'b0100, 'h201, -1};
        tbl[2] = '{1'b0, 4'b0100, 4'b0100, 'h202,  3};
        tbl[3] = '{1'b1, 4'b1111, 4'b0001, 'h000, -1};
        tbl[4] = '{1'b0, 4'b1111, 4'b0010, 'h100, -1};
        tbl[5] = '{1'b0, 4'b1111, 4'b0100, 'h200, -1};
        tbl[6] = '{1'b0, 4'b1111, 4'b1000, 'h300, -1};
        tbl[7] = '{1'b0, 4'b1111, 4'b0001, 'h001, -1};
        tbl[8] = '{1'b0, 4'b1111, 4'b0010, 'h101, -1};

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].rst_first) do_reset();
            cycle(tbl[i].v, '0);
            check("tbl_ready", 64'(rdy_seen), 64'(tbl[i].exp_ready));
            check("tbl_we",    64'(we),       64'(1));
            check("tbl_waddr", 64'(waddr),    64'(tbl[i].exp_waddr));
            if (tbl[i].exp_lvl2 >= 0)
                check("tbl_lvl2", 64'(ch_level[2*LW +: LW]), 64'(tbl[i].exp_lvl2));
        end

        // Fill ch1 to capacity; it must drop out while others keep going.
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(4'b0010, '0);
        check("full_flag", 64'(ch_full[1]), 64'(1));
        check("full_wptr", 64'(ch_wptr[1*CH_AW +: CH_AW]), 64'(0));
        for (int i = 0; i < 6; i++) begin
            cycle(4'b1111, '0);
            check("full_no_rdy1", 64'(rdy_seen[1]), 64'(0));
            check("full_others",  64'(|rdy_seen),   64'(1));
        end
        cycle(4'b0010, 4'b0010);
        check("free_same_cycle", 64'(rdy_seen), 64'(0));
        cycle(4'b0010, '0);
        check("extra_grant",  64'(rdy_seen), 64'(4'b0010));
        check("extra_waddr",  64'(waddr),    64'('h100));
        check("extra_wptr",   64'(ch_wptr[1*CH_AW +: CH_AW]), 64'(1));
        check("extra_full",   64'(ch_full[1]), 64'(1));
        cycle(4'b0010, '0);
        check("only_one_more", 64'(rdy_seen), 64'(0));

        // Grant and free together, then free on an empty channel.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(4'b0001, '0);
        cycle(4'b0001, 4'b0001);
        check("simul_lvl0", 64'(ch_level[0 +: LW]), 64'(5));
        check("simul_err",  64'(err_underflow), 64'(0));
        cycle('0, 4'b1000);
        check("uflow_err",  64'(err_underflow), 64'(1));
        check("uflow_lvl3", 64'(ch_level[3*LW +: LW]), 64'(0));

        // Randomized traffic with occasional free pulses.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [NCH-1:0] v;
            logic [NCH-1:0] f;
            v = NCH'($urandom);
            for (int c = 0; c < NCH; c++) f[c] = ($urandom_range(0, 7) == 0);
            cycle(v, f);
        end

        // Asynchronous reset in the middle of a 4-channel burst.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(4'b1111, '0);
        #2;
        rst_int = 1'b0;
        #1;
        check("async_we",    64'(we),       64'(0));
        check("async_level", 64'(ch_level), 64'(0));
        check("async_wptr",  64'(ch_wptr),  64'(0));
        model_reset();
        check_state("async");
        req_valid = '0;
        @(negedge wclk_int);
        rst_int = 1'b1;
        cycle(4'b1111, '0);
        check("after_rst_grant", 64'(rdy_seen), 64'(4'b0001));
        check("after_rst_waddr", 64'(waddr),    64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
